// File: rtl/nios_project_btn_poller_pkg.sv
// Shared definitions for the button PIO poller: PIO register map and poller FSM states.
package nios_project_btn_poller_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int unsigned TMR_W = 24;

    typedef enum logic [2:0] {
        INIT_WR,
        IDLE,
        RD_LVL,
        LVL_DATA,
        RD_EDGE,
        EDGE_DATA,
        WR_CLR,
        EVENT
    } state_t;

endpackage

// File: rtl/nios_project_btn_poller_if.sv
// Avalon-MM link between the poller (master) and the button PIO (slave).
interface nios_project_btn_poller_if;

    logic [1:0]  avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    modport master (
        output avm_address, avm_read, avm_write, avm_writedata,
        input  avm_readdata, avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_writedata,
        output avm_readdata, avm_waitrequest
    );

endinterface

// File: rtl/nios_project_poll_timer.sv
// Reloadable down-counter pacing the timer-driven polls; zero flags expiry.
module nios_project_poll_timer #(
    parameter int unsigned WIDTH  = 24,
    parameter int unsigned PERIOD = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic dec,
    input  logic reload,
    output logic zero
);

    localparam logic [WIDTH-1:0] RELOAD_VAL = WIDTH'(PERIOD - 1);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= RELOAD_VAL;
        end else if (reload) begin
            count <= RELOAD_VAL;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/nios_project_btn_poller.sv
// Avalon-MM initiator that polls a single-button PIO, clears captured edges
// and reports each press as a pulse plus a wrapping count.
module nios_project_btn_poller
    import nios_project_btn_poller_pkg::*;
#(
    parameter int unsigned POLL_PERIOD   = 50000,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned IRQ_MASK_INIT = 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          pio_irq,
    nios_project_btn_poller_if.master     avm,
    output logic                          press_pulse,
    output logic [CNT_W-1:0]              press_count,
    output logic                          level,
    output logic                          busy
);

    state_t state;
    logic   tmr_zero;
    logic   poll_go;
    logic   accepted;
    logic   unused_rdata;

    // A single-button PIO only carries information in bit 0.
    assign unused_rdata = ^avm.avm_readdata[31:1];

    assign poll_go  = (state == IDLE) && enable && (tmr_zero || pio_irq);
    assign accepted = !avm.avm_waitrequest;

    nios_project_poll_timer #(
        .WIDTH  (TMR_W),
        .PERIOD (POLL_PERIOD)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .dec     ((state == IDLE) && enable),
        .reload  (poll_go),
        .zero    (tmr_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= INIT_WR;
            avm.avm_address   <= '0;
            avm.avm_read      <= 1'b0;
            avm.avm_write     <= 1'b0;
            avm.avm_writedata <= '0;
            press_pulse       <= 1'b0;
            press_count       <= '0;
            level             <= 1'b0;
            busy              <= 1'b0;
        end else begin
            press_pulse <= 1'b0;
            case (state)
                // First cycle after reset raises the strobe; the next cycles wait for acceptance.
                INIT_WR: begin
                    if (!avm.avm_write) begin
                        avm.avm_write     <= 1'b1;
                        avm.avm_address   <= ADDR_MASK;
                        avm.avm_writedata <= IRQ_MASK_INIT;
                        busy              <= 1'b1;
                    end else if (accepted) begin
                        avm.avm_write <= 1'b0;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end
                end
                IDLE: begin
                    if (poll_go) begin
                        avm.avm_read    <= 1'b1;
                        avm.avm_address <= ADDR_DATA;
                        busy            <= 1'b1;
                        state           <= RD_LVL;
                    end
                end
                RD_LVL: begin
                    if (accepted) begin
                        avm.avm_read <= 1'b0;
                        state        <= LVL_DATA;
                    end
                end
                LVL_DATA: begin
                    level           <= avm.avm_readdata[0];
                    avm.avm_read    <= 1'b1;
                    avm.avm_address <= ADDR_EDGE;
                    state           <= RD_EDGE;
                end
                RD_EDGE: begin
                    if (accepted) begin
                        avm.avm_read <= 1'b0;
                        state        <= EDGE_DATA;
                    end
                end
                EDGE_DATA: begin
                    if (avm.avm_readdata[0]) begin
                        avm.avm_write     <= 1'b1;
                        avm.avm_address   <= ADDR_EDGE;
                        avm.avm_writedata <= '0;
                        state             <= WR_CLR;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                WR_CLR: begin
                    if (accepted) begin
                        avm.avm_write <= 1'b0;
                        press_pulse   <= 1'b1;
                        press_count   <= press_count + CNT_W'(1);
                        state         <= EVENT;
                    end
                end
                EVENT: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nios_project_btn_poller.sv
// Directed bench for the button poller with a PIO responder model and transaction scoreboard.
module tb_nios_project_btn_poller;

    localparam int unsigned PERIOD = 8;
    localparam int unsigned CNT_W  = 2;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             enable = 1'b1;
    logic             pio_irq = 1'b0;
    logic             press_pulse;
    logic [CNT_W-1:0] press_count;
    logic             level;
    logic             busy;

    nios_project_btn_poller_if avm_bus ();

    nios_project_btn_poller #(
        .POLL_PERIOD   (PERIOD),
        .CNT_W         (CNT_W),
        .IRQ_MASK_INIT (1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .pio_irq     (pio_irq),
        .avm         (avm_bus),
        .press_pulse (press_pulse),
        .press_count (press_count),
        .level       (level),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_wr;
        logic [1:0]  addr;
        logic [31:0] data;
        int          cyc;
    } tx_t;

    typedef struct {
        int cyc;
        int cnt;
    } pulse_t;

    tx_t    exp_tx_q[$];
    pulse_t exp_p_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Responder model state
    logic        btn = 1'b0;
    logic        edge_cap = 1'b0;
    logic [31:0] mask_reg = '0;
    logic        rd_pend = 1'b0;
    logic [31:0] rd_val = '0;
    int          stall_cfg = 0;
    int          stall_left = 0;
    logic        stalled = 1'b0;
    logic [35:0] hold_v = '0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_tx(input logic is_wr, input logic [1:0] addr, input logic [31:0] data, input int c);
        tx_t t;
        t.is_wr = is_wr;
        t.addr  = addr;
        t.data  = data;
        t.cyc   = c;
        exp_tx_q.push_back(t);
    endtask

    task automatic push_pulse(input int c, input int cnt);
        pulse_t p;
        p.cyc = c;
        p.cnt = cnt;
        exp_p_q.push_back(p);
    endtask

    // One cycle: sample DUT mid-cycle, act as the PIO, drive inputs for the next edge.
    task automatic tick();
        logic        req;
        logic [35:0] cur;
        logic [31:0] obs_data;
        tx_t         e;
        pulse_t      p;
        @(negedge clk);
        cyc++;
        avm_bus.avm_readdata = rd_pend ? rd_val : 32'hA5A5_A5A5;
        rd_pend = 1'b0;
        if (press_pulse) begin
            if (exp_p_q.size() == 0) begin
                check("pulse_unexpected_cycle", 128'(cyc), 128'(0));
            end else begin
                p = exp_p_q.pop_front();
                check("pulse_cycle_count", 128'({cyc, 32'(press_count)}), 128'({p.cyc, p.cnt}));
            end
        end
        req = avm_bus.avm_read | avm_bus.avm_write;
        cur = {avm_bus.avm_read, avm_bus.avm_write, avm_bus.avm_address, avm_bus.avm_writedata};
        if (stalled) check("stall_hold", 128'(cur), 128'(hold_v));
        if (req) begin
            check("one_strobe", 128'(avm_bus.avm_read & avm_bus.avm_write), 128'(0));
            if (stall_left > 0) begin
                avm_bus.avm_waitrequest = 1'b1;
                stall_left--;
                stalled = 1'b1;
                hold_v  = cur;
            end else begin
                avm_bus.avm_waitrequest = 1'b0;
                stalled    = 1'b0;
                stall_left = stall_cfg;
                obs_data = avm_bus.avm_write ? avm_bus.avm_writedata : 32'd0;
                if (exp_tx_q.size() == 0) begin
                    check("tx_unexpected_cycle", 128'(cyc), 128'(0));
                end else begin
                    e = exp_tx_q.pop_front();
                    check("tx_cyc_wr_addr_data",
                          128'({cyc, avm_bus.avm_write, avm_bus.avm_address, obs_data}),
                          128'({e.cyc, e.is_wr, e.addr, e.data}));
                end
                if (avm_bus.avm_write) begin
                    if (avm_bus.avm_address == 2'd2) mask_reg = avm_bus.avm_writedata;
                    if (avm_bus.avm_address == 2'd3) edge_cap = 1'b0;
                end else begin
                    rd_pend = 1'b1;
                    case (avm_bus.avm_address)
                        2'd0:    rd_val = {31'd0, btn};
                        2'd2:    rd_val = mask_reg;
                        2'd3:    rd_val = {31'd0, edge_cap};
                        default: rd_val = 32'd0;
                    endcase
                end
            end
        end else begin
            avm_bus.avm_waitrequest = 1'b0;
            stalled = 1'b0;
        end
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    initial begin
        avm_bus.avm_readdata    = '0;
        avm_bus.avm_waitrequest = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_outputs",
              128'({avm_bus.avm_read, avm_bus.avm_write, avm_bus.avm_address, avm_bus.avm_writedata,
                    press_pulse, press_count, level, busy}), 128'(0));
        reset_n = 1'b1;
        cyc = 0;

        // Mask write, then timer polls with no captured edge
        btn = 1'b1;
        push_tx(1'b1, 2'd2, 32'd1, 1);
        push_tx(1'b0, 2'd0, 32'd0, 10);
        push_tx(1'b0, 2'd3, 32'd0, 12);
        push_tx(1'b0, 2'd0, 32'd0, 22);
        push_tx(1'b0, 2'd3, 32'd0, 24);
        run_to(2);
        check("busy_after_init", 128'(busy), 128'(0));
        check("count_after_init", 128'(press_count), 128'(0));
        check("mask_written", 128'(mask_reg), 128'(1));
        run_to(12);
        check("level_sampled", 128'(level), 128'(1));
        run_to(26);
        check("no_edge_polls_done", 128'(exp_tx_q.size()), 128'(0));

        // Captured edge: clear write then pulse 6 cycles after IDLE exit at 33
        edge_cap = 1'b1;
        push_tx(1'b0, 2'd0, 32'd0, 34);
        push_tx(1'b0, 2'd3, 32'd0, 36);
        push_tx(1'b1, 2'd3, 32'd0, 38);
        push_pulse(39, 1);
        run_to(39);
        check("count_first_press", 128'(press_count), 128'(1));
        run_to(40);
        check("pulse_one_cycle", 128'(press_pulse), 128'(0));

        // irq at timer=5 forces poll at 42; irq coinciding with expiry at 54 gives one poll
        push_tx(1'b0, 2'd0, 32'd0, 43);
        push_tx(1'b0, 2'd3, 32'd0, 45);
        push_tx(1'b0, 2'd0, 32'd0, 55);
        push_tx(1'b0, 2'd3, 32'd0, 57);
        run_to(42);
        pio_irq = 1'b1;
        tick();
        pio_irq = 1'b0;
        run_to(54);
        pio_irq = 1'b1;
        tick();
        pio_irq = 1'b0;
        run_to(59);
        check("irq_polls_done", 128'(exp_tx_q.size()), 128'(0));

        // Three-cycle stall on every request: pulse 15 cycles after exit at 66
        stall_cfg  = 3;
        stall_left = 3;
        edge_cap   = 1'b1;
        push_tx(1'b0, 2'd0, 32'd0, 70);
        push_tx(1'b0, 2'd3, 32'd0, 75);
        push_tx(1'b1, 2'd3, 32'd0, 80);
        push_pulse(81, 2);
        run_to(81);
        stall_cfg  = 0;
        stall_left = 0;

        // irq held: back-to-back presses every 7 cycles, count wraps 3,0,1
        run_to(82);
        edge_cap = 1'b1;
        pio_irq  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            push_tx(1'b0, 2'd0, 32'd0, 82 + 7 * k + 1);
            push_tx(1'b0, 2'd3, 32'd0, 82 + 7 * k + 3);
            push_tx(1'b1, 2'd3, 32'd0, 82 + 7 * k + 5);
            push_pulse(82 + 7 * k + 6, (3 + k) % 4);
        end
        push_tx(1'b0, 2'd0, 32'd0, 104);
        push_tx(1'b0, 2'd3, 32'd0, 106);
        for (int k = 0; k < 3; k++) begin
            run_to(82 + 7 * k + 6);
            if (k < 2) edge_cap = 1'b1;
        end
        run_to(104);
        pio_irq = 1'b0;

        // enable drops mid-poll: poll completes, then silence
        push_tx(1'b0, 2'd0, 32'd0, 116);
        push_tx(1'b0, 2'd3, 32'd0, 118);
        run_to(116);
        enable = 1'b0;
        run_to(220);
        check("disabled_no_requests", 128'(exp_tx_q.size()), 128'(0));
        check("disabled_busy", 128'(busy), 128'(0));

        // Re-enable, stall the clear write, then reset mid-transaction
        enable   = 1'b1;
        edge_cap = 1'b1;
        push_tx(1'b0, 2'd0, 32'd0, 228);
        push_tx(1'b0, 2'd3, 32'd0, 230);
        run_to(231);
        stall_left = 5;
        tick();
        check("wr_clr_pending",
              128'({avm_bus.avm_write, avm_bus.avm_address, avm_bus.avm_writedata}),
              128'({1'b1, 2'd3, 32'd0}));
        reset_n = 1'b0;
        #1;
        check("reset_abort_outputs",
              128'({avm_bus.avm_read, avm_bus.avm_write, avm_bus.avm_address, avm_bus.avm_writedata,
                    press_pulse, press_count, level, busy}), 128'(0));
        stalled    = 1'b0;
        stall_left = 0;
        stall_cfg  = 0;
        rd_pend    = 1'b0;
        avm_bus.avm_waitrequest = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        cyc = 0;

        // Restart: INIT_WR reissued, the uncleared edge is serviced on the first poll
        push_tx(1'b1, 2'd2, 32'd1, 1);
        push_tx(1'b0, 2'd0, 32'd0, 10);
        push_tx(1'b0, 2'd3, 32'd0, 12);
        push_tx(1'b1, 2'd3, 32'd0, 14);
        push_pulse(15, 1);
        run_to(2);
        check("busy_after_reinit", 128'(busy), 128'(0));
        check("count_after_reinit", 128'(press_count), 128'(0));
        run_to(16);
        check("count_after_restart_press", 128'(press_count), 128'(1));
        check("tx_queue_drained", 128'(exp_tx_q.size()), 128'(0));
        check("pulse_queue_drained", 128'(exp_p_q.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
